// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared types and constants for the two-requester ALU arbiter.
//   state_t  - arbiter FSM states (IDLE, EXEC, RESP)
//   NUM_REQ  - number of requesters sharing the ALU
//   OP_*     - ALU operation codes
package alu_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    localparam int NUM_REQ = 2;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_NOR  = 4'b1001;
    localparam logic [3:0] OP_SEQ  = 4'b1010;
    localparam logic [3:0] OP_SNE  = 4'b1011;
    localparam logic [3:0] OP_SLTU = 4'b1100;
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response bus between two requesters and the ALU arbiter.
//   req_valid/req_ready - per-requester request handshake (bit i = requester i)
//   req_op/req_a/req_b  - packed per-requester opcode and operands
//   rsp_valid/rsp_ready - one-hot response handshake to the granted requester
//   rsp_data            - shared result bus, meaningful while a rsp_valid bit is high
//   busy                - arbiter is not idle
//   slave modport: arbiter side; master modport: requester side
interface alu_arbiter_if
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
);
    logic [NUM_REQ-1:0]               req_valid;
    logic [NUM_REQ-1:0]               req_ready;
    logic [NUM_REQ*OPCODE_LENGTH-1:0] req_op;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_a;
    logic [NUM_REQ*DATA_WIDTH-1:0]    req_b;
    logic [NUM_REQ-1:0]               rsp_valid;
    logic [NUM_REQ-1:0]               rsp_ready;
    logic [DATA_WIDTH-1:0]            rsp_data;
    logic                             busy;
    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu: combinational team ALU.
//   i_op - operation code, i_a/i_b - SrcA/SrcB, o_y - result
//   Add/sub wrap modulo 2^DATA_WIDTH, shifts use i_b[4:0], undefined opcodes give 0.
module alu
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
)
(
    input  logic [OPCODE_LENGTH-1:0] i_op,
    input  logic [DATA_WIDTH-1:0]    i_a,
    input  logic [DATA_WIDTH-1:0]    i_b,
    output logic [DATA_WIDTH-1:0]    o_y
);
    logic [4:0] w_sh;
    assign w_sh = i_b[4:0];
    always_comb begin
        case (i_op)
            OPCODE_LENGTH'(OP_AND):  o_y = i_a & i_b;
            OPCODE_LENGTH'(OP_OR):   o_y = i_a | i_b;
            OPCODE_LENGTH'(OP_ADD):  o_y = i_a + i_b;
            OPCODE_LENGTH'(OP_SUB):  o_y = i_a - i_b;
            OPCODE_LENGTH'(OP_SLL):  o_y = i_a << w_sh;
            OPCODE_LENGTH'(OP_SLT):  o_y = DATA_WIDTH'($signed(i_a) < $signed(i_b));
            OPCODE_LENGTH'(OP_XOR):  o_y = i_a ^ i_b;
            OPCODE_LENGTH'(OP_SRL):  o_y = i_a >> w_sh;
            OPCODE_LENGTH'(OP_SRA):  o_y = $signed(i_a) >>> w_sh;
            OPCODE_LENGTH'(OP_NOR):  o_y = ~(i_a | i_b);
            OPCODE_LENGTH'(OP_SEQ):  o_y = DATA_WIDTH'(i_a == i_b);
            OPCODE_LENGTH'(OP_SNE):  o_y = DATA_WIDTH'(i_a != i_b);
            OPCODE_LENGTH'(OP_SLTU): o_y = DATA_WIDTH'(i_a < i_b);
            default:                 o_y = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters with round-robin priority.
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset, aborts any transaction in flight
//   bus   - slave side of alu_arbiter_if (request/response handshakes, busy)
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
)
(
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    state_t                   r_state;
    logic                     r_ptr;
    logic                     r_gnt;
    logic                     r_busy;
    logic [NUM_REQ-1:0]       r_rsp_valid;
    logic [OPCODE_LENGTH-1:0] r_op;
    logic [DATA_WIDTH-1:0]    r_a;
    logic [DATA_WIDTH-1:0]    r_b;
    logic [DATA_WIDTH-1:0]    r_rsp_data;
    logic [DATA_WIDTH-1:0]    w_y;
    logic                     w_any;
    logic                     w_gnt;
    assign w_any = |bus.req_valid;
    // Pointer only matters on contention; a lone requester always wins.
    assign w_gnt = &bus.req_valid ? r_ptr : bus.req_valid[1];
    // Ready is combinational so the grant is visible in the accepting cycle;
    // it is masked by reset so every output reads zero while reset is held.
    assign bus.req_ready = (r_state == IDLE && w_any && !reset) ? (w_gnt ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = r_busy;
    alu #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_LENGTH(OPCODE_LENGTH)
    ) u_alu (
        .i_op(r_op),
        .i_a (r_a),
        .i_b (r_b),
        .o_y (w_y)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ptr       <= 1'b0;
            r_gnt       <= 1'b0;
            r_busy      <= 1'b0;
            r_rsp_valid <= '0;
            r_op        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_gnt;
                        r_op    <= w_gnt ? bus.req_op[2*OPCODE_LENGTH-1:OPCODE_LENGTH] : bus.req_op[OPCODE_LENGTH-1:0];
                        r_a     <= w_gnt ? bus.req_a[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_a[DATA_WIDTH-1:0];
                        r_b     <= w_gnt ? bus.req_b[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_b[DATA_WIDTH-1:0];
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_y;
                    r_rsp_valid <= r_gnt ? 2'b10 : 2'b01;
                    r_state     <= RESP;
                end
                RESP: begin
                    // Only the granted requester's rsp_ready closes the response.
                    if (bus.rsp_ready[r_gnt]) begin
                        r_rsp_valid <= '0;
                        r_busy      <= 1'b0;
                        r_ptr       <= ~r_gnt;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;
    localparam int DW = 32;
    localparam int OL = 4;
    typedef struct {
        int          id;
        logic [31:0] data;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    int n_tests = 0;
    int n_fail = 0;
    int both_hi = 0;
    exp_t sb[$];
    logic [3:0]  drv_op [2];
    logic [31:0] drv_a  [2];
    logic [31:0] drv_b  [2];
    always #5 clk = ~clk;
    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) bus ();
    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OL)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    always @(negedge clk) if (bus.req_ready === 2'b11) both_hi++;
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int s;
        s = int'(b[4:0]);
        if (op == OP_AND)  return a & b;
        if (op == OP_OR)   return a | b;
        if (op == OP_ADD)  return a + b;
        if (op == OP_SUB)  return a - b;
        if (op == OP_SLL)  return a << s;
        if (op == OP_SLT)  return {31'b0, $signed(a) < $signed(b)};
        if (op == OP_XOR)  return a ^ b;
        if (op == OP_SRL)  return a >> s;
        if (op == OP_SRA)  return 32'($signed(a) >>> s);
        if (op == OP_NOR)  return ~(a | b);
        if (op == OP_SEQ)  return {31'b0, a == b};
        if (op == OP_SNE)  return {31'b0, a != b};
        if (op == OP_SLTU) return {31'b0, a < b};
        return 32'd0;
    endfunction
    function automatic exp_t pop_exp();
        exp_t e;
        e.id = -1;
        e.data = '0;
        if (sb.size() > 0) e = sb.pop_front();
        return e;
    endfunction
    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        drv_op[i] = op;
        drv_a[i]  = a;
        drv_b[i]  = b;
        bus.req_op[i*OL +: OL] = op;
        bus.req_a[i*DW +: DW]  = a;
        bus.req_b[i*DW +: DW]  = b;
        bus.req_valid[i] = 1'b1;
    endtask
    // Waits for an accept, pushes the expected result, optionally withdraws
    // and scrambles the winner's request, then waits for the response.
    task automatic do_txn(input bit drop, output int gid, output logic [1:0] rv,
                          output logic [31:0] d, output int lat, output time ta);
        gid = -1;
        rv = 2'b00;
        d = '0;
        lat = 0;
        ta = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (bus.req_ready != 2'b00) begin
                gid = bus.req_ready[1] ? 1 : 0;
                ta = $time;
                sb.push_back('{id: gid, data: model(drv_op[gid], drv_a[gid], drv_b[gid])});
                break;
            end
            @(negedge clk);
        end
        if (gid < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed %b, required a grant", bus.req_ready);
            return;
        end
        @(posedge clk);
        #1;
        if (drop) begin
            bus.req_valid[gid] = 1'b0;
            bus.req_op[gid*OL +: OL] = 4'($urandom);
            bus.req_a[gid*DW +: DW]  = $urandom;
            bus.req_b[gid*DW +: DW]  = $urandom;
        end
        for (int c = 0; c < 20 && rv == 2'b00; c++) begin
            @(negedge clk);
            lat++;
            if (bus.rsp_valid != 2'b00) begin
                rv = bus.rsp_valid;
                d = bus.rsp_data;
            end
        end
        if (rv == 2'b00) begin
            n_tests++;
            n_fail++;
            $display("FAIL resp_timeout: rsp_valid stayed 00, required a response");
        end
    endtask
    task automatic test_reset();
        reset = 1'b1;
        @(negedge clk);
        n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got %b exp 00", bus.req_ready); end
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 00", bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== 32'd0) begin n_fail++; $display("FAIL reset_rsp_data got %h exp 0", bus.rsp_data); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        reset = 1'b0;
        @(negedge clk);
    endtask
    task automatic test_add();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        bus.rsp_ready = 2'b11;
        set_req(0, OP_ADD, 32'd5, 32'd7);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 0) begin n_fail++; $display("FAIL add_grant got %0d exp 0", gid); end
        n_tests++; if (rv !== 2'b01) begin n_fail++; $display("FAIL add_rsp_valid got %b exp 01", rv); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL add_latency got %0d exp 2", lat); end
        n_tests++; if (d !== e.data || d !== 32'd12) begin n_fail++; $display("FAIL add_data got %0d exp %0d", d, e.data); end
        @(negedge clk);
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL add_busy_after got %b exp 0", bus.busy); end
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL add_rsp_clear got %b exp 00", bus.rsp_valid); end
    endtask
    task automatic test_priority();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        set_req(0, OP_SUB, 32'd3, 32'd5);
        set_req(1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 0 || rv !== 2'b01) begin n_fail++; $display("FAIL prio_first_grant got %0d/%b exp 0/01", gid, rv); end
        n_tests++; if (d !== e.data || d !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL prio_sub_data got %h exp %h", d, e.data); end
        n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy got %b exp 1", bus.busy); end
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 1 || rv !== 2'b10) begin n_fail++; $display("FAIL prio_second_grant got %0d/%b exp 1/10", gid, rv); end
        n_tests++; if (d !== e.data || d !== 32'd1) begin n_fail++; $display("FAIL prio_slt_data got %h exp %h", d, e.data); end
    endtask
    task automatic test_back_to_back();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta, tprev;
        exp_t e;
        tprev = 0;
        set_req(0, 4'($urandom_range(0, 12)), $urandom, $urandom);
        set_req(1, 4'($urandom_range(0, 12)), $urandom, $urandom);
        for (int k = 0; k < 4; k++) begin
            do_txn(1'b0, gid, rv, d, lat, ta);
            e = pop_exp();
            n_tests++; if (gid !== k % 2) begin n_fail++; $display("FAIL b2b_order txn %0d got %0d exp %0d", k, gid, k % 2); end
            n_tests++; if (d !== e.data || rv !== (gid == 1 ? 2'b10 : 2'b01)) begin n_fail++; $display("FAIL b2b_data txn %0d got %h/%b exp %h", k, d, rv, e.data); end
            if (k > 0) begin
                n_tests++; if (ta - tprev !== 30) begin n_fail++; $display("FAIL b2b_spacing txn %0d got %0t exp 30", k, ta - tprev); end
            end
            tprev = ta;
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_tests++; if (both_hi !== 0) begin n_fail++; $display("FAIL b2b_ready_onehot got %0d double grants exp 0", both_hi); end
    endtask
    task automatic test_hold();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        bus.rsp_ready = 2'b01;
        set_req(1, OP_SRA, 32'h8000_0000, 32'd4);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 1 || rv !== 2'b10) begin n_fail++; $display("FAIL hold_grant got %0d/%b exp 1/10", gid, rv); end
        n_tests++; if (d !== e.data || d !== 32'hF800_0000) begin n_fail++; $display("FAIL hold_data got %h exp %h", d, e.data); end
        set_req(0, OP_OR, 32'd1, 32'd2);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_tests++; if (bus.rsp_valid !== 2'b10) begin n_fail++; $display("FAIL hold_rsp_valid cyc %0d got %b exp 10", c, bus.rsp_valid); end
            n_tests++; if (bus.rsp_data !== 32'hF800_0000) begin n_fail++; $display("FAIL hold_rsp_data cyc %0d got %h exp f8000000", c, bus.rsp_data); end
            n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL hold_req_ready cyc %0d got %b exp 00", c, bus.req_ready); end
            n_tests++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL hold_busy cyc %0d got %b exp 1", c, bus.busy); end
        end
        bus.req_valid[0] = 1'b0;
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        n_tests++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL hold_release got %b/%b exp 00/0", bus.rsp_valid, bus.busy); end
    endtask
    task automatic test_reset_exec();
        int gid, lat, spurious;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        bus.rsp_ready = 2'b11;
        set_req(0, OP_XOR, 32'hF0, 32'h0F);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 0 || d !== e.data || d !== 32'hFF) begin n_fail++; $display("FAIL rst_pre_txn got %0d/%h exp 0/%h", gid, d, e.data); end
        @(negedge clk);
        set_req(1, OP_ADD, 32'd100, 32'd23);
        #1;
        n_tests++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL rst_pre_ready got %b exp 10", bus.req_ready); end
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        reset = 1'b1;
        #1;
        n_tests++; if (bus.rsp_valid !== 2'b00) begin n_fail++; $display("FAIL rst_exec_rsp_valid got %b exp 00", bus.rsp_valid); end
        n_tests++; if (bus.rsp_data !== 32'd0) begin n_fail++; $display("FAIL rst_exec_rsp_data got %h exp 0", bus.rsp_data); end
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_exec_busy got %b exp 0", bus.busy); end
        n_tests++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL rst_exec_req_ready got %b exp 00", bus.req_ready); end
        @(negedge clk);
        reset = 1'b0;
        spurious = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) spurious++;
        end
        n_tests++; if (spurious !== 0) begin n_fail++; $display("FAIL rst_no_response got %0d active cycles exp 0", spurious); end
        set_req(0, OP_SLL, 32'd1, 32'd31);
        set_req(1, OP_SLTU, 32'd1, 32'hFFFF_FFFF);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 0 || d !== e.data || d !== 32'h8000_0000) begin n_fail++; $display("FAIL rst_ptr_grant got %0d/%h exp 0/%h", gid, d, e.data); end
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 1 || d !== e.data || d !== 32'd1) begin n_fail++; $display("FAIL rst_second_grant got %0d/%h exp 1/%h", gid, d, e.data); end
    endtask
    task automatic test_undef();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        @(negedge clk);
        set_req(0, 4'b1111, 32'd9, 32'd9);
        do_txn(1'b1, gid, rv, d, lat, ta);
        e = pop_exp();
        n_tests++; if (gid !== 0 || d !== e.data || d !== 32'd0) begin n_fail++; $display("FAIL undef_op got %0d/%h exp 0/0", gid, d); end
    endtask
    task automatic test_ops();
        int gid, lat;
        logic [1:0] rv;
        logic [31:0] d;
        time ta;
        exp_t e;
        for (int op = 0; op < 16; op++) begin
            @(negedge clk);
            set_req(op % 2, 4'(op), $urandom, (op % 3 == 0) ? 32'h7FFF_FFFF : $urandom);
            do_txn(1'b1, gid, rv, d, lat, ta);
            e = pop_exp();
            n_tests++; if (gid !== op % 2 || d !== e.data) begin n_fail++; $display("FAIL op_%0d got %0d/%h exp %0d/%h", op, gid, d, op % 2, e.data); end
        end
    endtask
    initial begin
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_op = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 2'b11;
        for (int i = 0; i < 2; i++) begin
            drv_op[i] = '0;
            drv_a[i] = '0;
            drv_b[i] = '0;
        end
        repeat (2) @(negedge clk);
        test_reset();
        test_add();
        test_priority();
        test_back_to_back();
        test_hold();
        test_reset_exec();
        test_undef();
        test_ops();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
